// File: rtl/rx_nco_bank.sv
// rx_nco_bank: bank of independent phase accumulators (NCOs), each producing
// SPC parallel phase samples per clock for a polyphase receive datapath.
//
// Ports
//   clock         sole clock, rising edge
//   reset         asynchronous active-high reset, clears all state
//   enable        advance all accumulators and register a new output word
//   phase_inc_in  candidate increments, channel c at [c*PHASE_W +: PHASE_W]
//   inc_load      per-channel strobe capturing its phase_inc_in slice
//   phase_clr     per-channel synchronous accumulator clear
//   phase_out     lane k of channel c at [(c*SPC+k)*PHASE_W +: PHASE_W]
//   phase_valid   phase_out was updated on the last edge
//   inc_active    increment registers currently in use
//
// Flow control: enable is a qualifier with no backpressure. Every edge that
// samples enable=1 registers a new phase_out word and phase_valid is high for
// exactly the following cycle; with enable=0 phase_out holds and
// phase_valid is low. There is no ready signal.
//
// The block has no FSM; its only state is inc[], acc[] and the output word.
module rx_nco_bank #(
  parameter int NUM_CH  = 3,
  parameter int SPC     = 8,
  parameter int PHASE_W = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [NUM_CH*PHASE_W-1:0]         phase_inc_in,
  input  logic [NUM_CH-1:0]                 inc_load,
  input  logic [NUM_CH-1:0]                 phase_clr,
  output logic [NUM_CH*SPC*PHASE_W-1:0]     phase_out,
  output logic                              phase_valid,
  output logic [NUM_CH*PHASE_W-1:0]         inc_active
);

  localparam int NUM_LANES = NUM_CH * SPC;

  logic [PHASE_W-1:0] inc_q    [NUM_CH];
  logic [PHASE_W-1:0] acc_q    [NUM_CH];
  logic [PHASE_W-1:0] step     [NUM_CH];
  logic [PHASE_W-1:0] lane_nxt [NUM_LANES];
  logic [PHASE_W-1:0] phase_q  [NUM_LANES];
  logic               valid_q;

  // Lane values and per-word accumulator step. All arithmetic is modulo
  // 2^PHASE_W: operands are cast to PHASE_W bits so products truncate.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      step[c] = PHASE_W'(SPC) * inc_q[c];
      for (int k = 0; k < SPC; k++) begin
        lane_nxt[c*SPC+k] = acc_q[c] + PHASE_W'(k) * inc_q[c];
      end
    end
  end

  // Every update uses pre-edge acc/inc, so a load or clear landing together
  // with enable only affects the word after this one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        inc_q[c] <= '0;
        acc_q[c] <= '0;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        phase_q[i] <= '0;
      end
    end else begin
      valid_q <= enable;
      for (int c = 0; c < NUM_CH; c++) begin
        if (inc_load[c]) begin
          inc_q[c] <= phase_inc_in[c*PHASE_W +: PHASE_W];
        end
        if (phase_clr[c]) begin
          acc_q[c] <= '0;
        end else if (enable) begin
          acc_q[c] <= acc_q[c] + step[c];
        end
      end
      if (enable) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          phase_q[i] <= lane_nxt[i];
        end
      end
    end
  end

  assign phase_valid = valid_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign phase_out[i*PHASE_W +: PHASE_W] = phase_q[i];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign inc_active[c*PHASE_W +: PHASE_W] = inc_q[c];
  end

endmodule

// File: tb/tb_rx_nco_bank.sv
// Directed, table-driven bench for rx_nco_bank (NUM_CH=3, SPC=8, PHASE_W=16).
// Each table row is one clock: inputs driven on the falling edge, outputs
// checked 1 time unit after the following rising edge. Expected words are
// described per channel as (lane0, step) pairs computed by hand and expanded
// into lane values modulo 2^16.
module tb_rx_nco_bank;

  localparam int NUM_CH  = 3;
  localparam int SPC     = 8;
  localparam int PHASE_W = 16;
  localparam int OUT_W   = NUM_CH * SPC * PHASE_W;
  localparam int INC_W   = NUM_CH * PHASE_W;

  logic               clock;
  logic               reset;
  logic               enable;
  logic [INC_W-1:0]   phase_inc_in;
  logic [NUM_CH-1:0]  inc_load;
  logic [NUM_CH-1:0]  phase_clr;
  logic [OUT_W-1:0]   phase_out;
  logic               phase_valid;
  logic [INC_W-1:0]   inc_active;

  int n_checks = 0;
  int n_errors = 0;

  logic [OUT_W-1:0] exp_q[$];

  rx_nco_bank #(.NUM_CH(NUM_CH), .SPC(SPC), .PHASE_W(PHASE_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .phase_inc_in (phase_inc_in),
    .inc_load     (inc_load),
    .phase_clr    (phase_clr),
    .phase_out    (phase_out),
    .phase_valid  (phase_valid),
    .inc_active   (inc_active)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic [2:0]  ld;
    logic [2:0]  clr;
    logic [15:0] inc_val;  // broadcast to all slices; only strobed ones load
    logic        vld;
    logic [15:0] l0 [3];
    logic [15:0] st [3];
    logic [15:0] inc [3];
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic [2:0] ld, input logic [2:0] clr,
                     input logic [15:0] inc_val, input logic vld,
                     input logic [15:0] l00, input logic [15:0] s0,
                     input logic [15:0] l01, input logic [15:0] s1,
                     input logic [15:0] l02, input logic [15:0] s2,
                     input logic [15:0] i0, input logic [15:0] i1,
                     input logic [15:0] i2);
    vec_t v;
    v.en = en; v.ld = ld; v.clr = clr; v.inc_val = inc_val; v.vld = vld;
    v.l0[0] = l00; v.st[0] = s0;
    v.l0[1] = l01; v.st[1] = s1;
    v.l0[2] = l02; v.st[2] = s2;
    v.inc[0] = i0; v.inc[1] = i1; v.inc[2] = i2;
    vecs.push_back(v);
  endtask

  function automatic logic [OUT_W-1:0] expand(input vec_t v);
    logic [OUT_W-1:0] w;
    logic [15:0] lane;
    w = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < SPC; k++) begin
        lane = v.l0[c] + 16'(k) * v.st[c];
        w[(c*SPC+k)*PHASE_W +: PHASE_W] = lane;
      end
    end
    return w;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [OUT_W-1:0] act,
                       input logic [OUT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " valid"}, OUT_W'(phase_valid), '0);
    check({tag, " phase_out"}, phase_out, '0);
    check({tag, " inc_active"}, OUT_W'(inc_active), '0);
  endtask

  // ---------------- driver ----------------
  task automatic apply(input int idx);
    vec_t v;
    logic [OUT_W-1:0] exp_w;
    logic [INC_W-1:0] exp_inc;
    v = vecs[idx];
    @(negedge clock);
    enable       = v.en;
    inc_load     = v.ld;
    phase_clr    = v.clr;
    phase_inc_in = {v.inc_val, v.inc_val, v.inc_val};
    exp_q.push_back(expand(v));
    @(posedge clock);
    #1;
    exp_w   = exp_q.pop_front();
    exp_inc = {v.inc[2], v.inc[1], v.inc[0]};
    check($sformatf("row%0d valid", idx), OUT_W'(phase_valid), OUT_W'(v.vld));
    check($sformatf("row%0d phase_out", idx), phase_out, exp_w);
    check($sformatf("row%0d inc_active", idx), OUT_W'(inc_active), OUT_W'(exp_inc));
  endtask

  // ---------------- test ----------------
  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    inc_load     = '0;
    phase_clr    = '0;
    phase_inc_in = '0;

    //   en  ld      clr     val      vld  ch0 l0/step       ch1 l0/step       ch2 l0/step       inc0      inc1      inc2
    // basic run on ch0
    add(0, 3'b001, 3'b000, 16'h0100, 0, 16'h0000,16'h0000, 16'h0000,16'h0000, 16'h0000,16'h0000, 16'h0100, 16'h0000, 16'h0000); // 0
    add(1, 3'b000, 3'b000, 16'h0000, 1, 16'h0000,16'h0100, 16'h0000,16'h0000, 16'h0000,16'h0000, 16'h0100, 16'h0000, 16'h0000); // 1
    add(1, 3'b000, 3'b000, 16'h0000, 1, 16'h0800,16'h0100, 16'h0000,16'h0000, 16'h0000,16'h0000, 16'h0100, 16'h0000, 16'h0000); // 2
    // ch1 wrap: load with enable uses old inc=0 this word
    add(1, 3'b010, 3'b000, 16'h4000, 1, 16'h1000,16'h0100, 16'h0000,16'h0000, 16'h0000,16'h0000, 16'h0100, 16'h4000, 16'h0000); // 3
    add(1, 3'b000, 3'b000, 16'h0000, 1, 16'h1800,16'h0100, 16'h0000,16'h4000, 16'h0000,16'h0000, 16'h0100, 16'h4000, 16'h0000); // 4
    // ch2 starts at 0x0010
    add(1, 3'b100, 3'b000, 16'h0010, 1, 16'h2000,16'h0100, 16'h0000,16'h4000, 16'h0000,16'h0000, 16'h0100, 16'h4000, 16'h0010); // 5
    add(1, 3'b000, 3'b000, 16'h0000, 1, 16'h2800,16'h0100, 16'h0000,16'h4000, 16'h0000,16'h0010, 16'h0100, 16'h4000, 16'h0010); // 6
    // ch2 load 0x0020 with enable: this word still 0x0010
    add(1, 3'b100, 3'b000, 16'h0020, 1, 16'h3000,16'h0100, 16'h0000,16'h4000, 16'h0080,16'h0010, 16'h0100, 16'h4000, 16'h0020); // 7
    add(1, 3'b000, 3'b000, 16'h0000, 1, 16'h3800,16'h0100, 16'h0000,16'h4000, 16'h0100,16'h0020, 16'h0100, 16'h4000, 16'h0020); // 8
    // clear ch0 with enable: word from old acc, next starts at 0
    add(1, 3'b000, 3'b001, 16'h0000, 1, 16'h4000,16'h0100, 16'h0000,16'h4000, 16'h0200,16'h0020, 16'h0100, 16'h4000, 16'h0020); // 9
    add(1, 3'b000, 3'b000, 16'h0000, 1, 16'h0000,16'h0100, 16'h0000,16'h4000, 16'h0300,16'h0020, 16'h0100, 16'h4000, 16'h0020); // 10
    // enable low 3 cycles: frozen
    add(0, 3'b000, 3'b000, 16'h0000, 0, 16'h0000,16'h0100, 16'h0000,16'h4000, 16'h0300,16'h0020, 16'h0100, 16'h4000, 16'h0020); // 11
    add(0, 3'b000, 3'b000, 16'h0000, 0, 16'h0000,16'h0100, 16'h0000,16'h4000, 16'h0300,16'h0020, 16'h0100, 16'h4000, 16'h0020); // 12
    add(0, 3'b000, 3'b000, 16'h0000, 0, 16'h0000,16'h0100, 16'h0000,16'h4000, 16'h0300,16'h0020, 16'h0100, 16'h4000, 16'h0020); // 13
    add(1, 3'b000, 3'b000, 16'h0000, 1, 16'h0800,16'h0100, 16'h0000,16'h4000, 16'h0400,16'h0020, 16'h0100, 16'h4000, 16'h0020); // 14
    // clear + load ch1 together, enable low
    add(0, 3'b010, 3'b010, 16'h0001, 0, 16'h0800,16'h0100, 16'h0000,16'h4000, 16'h0400,16'h0020, 16'h0100, 16'h0001, 16'h0020); // 15
    add(1, 3'b000, 3'b000, 16'h0000, 1, 16'h1000,16'h0100, 16'h0000,16'h0001, 16'h0500,16'h0020, 16'h0100, 16'h0001, 16'h0020); // 16
    // clear + load ch2 with enable
    add(1, 3'b100, 3'b100, 16'h1000, 1, 16'h1800,16'h0100, 16'h0008,16'h0001, 16'h0600,16'h0020, 16'h0100, 16'h0001, 16'h1000); // 17
    add(1, 3'b000, 3'b000, 16'h0000, 1, 16'h2000,16'h0100, 16'h0010,16'h0001, 16'h0000,16'h1000, 16'h0100, 16'h0001, 16'h1000); // 18
    // ch2 accumulator wraps past 2^16
    add(1, 3'b000, 3'b000, 16'h0000, 1, 16'h2800,16'h0100, 16'h0018,16'h0001, 16'h8000,16'h1000, 16'h0100, 16'h0001, 16'h1000); // 19
    add(1, 3'b000, 3'b000, 16'h0000, 1, 16'h3000,16'h0100, 16'h0020,16'h0001, 16'h0000,16'h1000, 16'h0100, 16'h0001, 16'h1000); // 20

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i);
    end

    // asynchronous reset between edges while running
    @(negedge clock);
    enable = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");

    // loads/clears while reset is held are discarded
    @(negedge clock);
    inc_load     = 3'b111;
    phase_clr    = 3'b111;
    phase_inc_in = {16'h1234, 16'h5678, 16'h9abc};
    @(posedge clock);
    #1;
    check_zero("reset_held");
    @(negedge clock);
    reset     = 1'b0;
    enable    = 1'b0;
    inc_load  = '0;
    phase_clr = '0;
    @(posedge clock);
    #1;
    check_zero("post_reset");

    // the basic run reproduces from zero state
    for (int i = 0; i < 3; i++) begin
      apply(i);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
